// File: rtl/layer_norm_scheduler.sv
// rtl/layer_norm_scheduler.sv - round-robin sharing of one layer_norm datapath between two requesters
module layer_norm_scheduler #(
    parameter int DIM        = 4,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 63
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req0_valid,
    input  logic [DIM*DATA_WIDTH-1:0] req0_x,
    output logic                      req0_ready,
    input  logic                      req1_valid,
    input  logic [DIM*DATA_WIDTH-1:0] req1_x,
    output logic                      req1_ready,
    input  logic                      cfg_we,
    input  logic                      cfg_sel,
    input  logic [DIM*DATA_WIDTH-1:0] cfg_gamma,
    input  logic [DIM*DATA_WIDTH-1:0] cfg_beta,
    output logic                      ln_valid_in,
    output logic [DIM*DATA_WIDTH-1:0] ln_x,
    output logic [DIM*DATA_WIDTH-1:0] ln_gamma,
    output logic [DIM*DATA_WIDTH-1:0] ln_beta,
    input  logic [DIM*DATA_WIDTH-1:0] ln_y,
    input  logic                      ln_valid_out,
    output logic                      rsp_valid,
    output logic                      rsp_id,
    output logic [DIM*DATA_WIDTH-1:0] rsp_y,
    output logic                      rsp_err,
    input  logic                      rsp_ready,
    output logic                      busy,
    output logic                      err_timeout,
    input  logic                      err_clr
);
    localparam int VW = DIM * DATA_WIDTH;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [DATA_WIDTH-1:0] ONE       = DATA_WIDTH'(256);
    localparam logic [VW-1:0]         GAMMA_RST = {DIM{ONE}};
    localparam logic [CW-1:0]         CNT_LAST  = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state, state_nx;
    logic            last_grant;
    logic            grant_id;
    logic            accept;
    logic            result_hit;
    logic            timeout_hit;
    logic [CW-1:0]   wait_cnt;
    logic [VW-1:0]   gamma0, beta0, gamma1, beta1;
    logic [VW-1:0]   hold_x, hold_gamma, hold_beta;
    logic            hold_id;

    // On a tie the requester not served last wins; otherwise the lone requester wins.
    always_comb begin
        grant_id    = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        accept      = (state == IDLE) && (req0_valid || req1_valid) && rst_n;
        req0_ready  = accept && !grant_id;
        req1_ready  = accept && grant_id;
        result_hit  = (state == WAIT) && ln_valid_out;
        timeout_hit = (state == WAIT) && !ln_valid_out && (wait_cnt == CNT_LAST);
    end

    always_comb begin
        state_nx    = state;
        ln_valid_in = 1'b0;
        rsp_valid   = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE:  if (accept) state_nx = ISSUE;
            ISSUE: begin
                ln_valid_in = 1'b1;
                state_nx    = WAIT;
            end
            WAIT:  if (result_hit || timeout_hit) state_nx = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            gamma0      <= GAMMA_RST;
            beta0       <= '0;
            gamma1      <= GAMMA_RST;
            beta1       <= '0;
            hold_id     <= 1'b0;
            hold_x      <= '0;
            hold_gamma  <= '0;
            hold_beta   <= '0;
            wait_cnt    <= '0;
            rsp_y       <= '0;
            rsp_err     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_nx;
            if (cfg_we) begin
                if (cfg_sel) begin
                    gamma1 <= cfg_gamma;
                    beta1  <= cfg_beta;
                end else begin
                    gamma0 <= cfg_gamma;
                    beta0  <= cfg_beta;
                end
            end
            // Capture reads the config regs before any same-cycle write lands.
            if (accept) begin
                hold_id    <= grant_id;
                hold_x     <= grant_id ? req1_x : req0_x;
                hold_gamma <= grant_id ? gamma1 : gamma0;
                hold_beta  <= grant_id ? beta1  : beta0;
                last_grant <= grant_id;
            end
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            if (result_hit) begin
                rsp_y   <= ln_y;
                rsp_err <= 1'b0;
            end else if (timeout_hit) begin
                rsp_y   <= '0;
                rsp_err <= 1'b1;
            end
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end
        end
    end

    assign rsp_id   = hold_id;
    assign ln_x     = hold_x;
    assign ln_gamma = hold_gamma;
    assign ln_beta  = hold_beta;
endmodule
